// File: rtl/mult_pkg.sv
// Shared types and constants for the Booth multiplier issue front/back-end.
package mult_pkg;

   localparam int MULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } issue_state_t;

   typedef struct packed {
      logic [MULT_WIDTH-1:0] m;
      logic [MULT_WIDTH-1:0] q;
   } op_pair_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Circular operand-pair buffer; DEPTH must be a power of two so pointers wrap by overflow.
module mult_op_fifo
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [2*WIDTH-1:0]           wdata,
   input  logic                         pop,
   output logic [2*WIDTH-1:0]           rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [CW-1:0]      count_q;
   logic               push_ok;
   logic               pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue controller: buffers operand pairs, starts the sequential multiplier, holds its
// product for the consumer, and flags a multiplier that never reports done.
module mult_issue_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH   = MULT_WIDTH,
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               src_valid,
   output logic               src_ready,
   input  logic [WIDTH-1:0]   src_multiplicand,
   input  logic [WIDTH-1:0]   src_multiplier,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_multiplicand,
   output logic [WIDTH-1:0]   mul_multiplier,
   input  logic               mul_done,
   input  logic [2*WIDTH-1:0] mul_product,
   output logic               dst_valid,
   input  logic               dst_ready,
   output logic [2*WIDTH-1:0] dst_product,
   output logic               busy,
   output logic               err,
   output issue_state_t       dbg_state
);

   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   issue_state_t                 state_q;
   logic [WIDTH-1:0]             mcand_q;
   logic [WIDTH-1:0]             mplier_q;
   logic                         start_q;
   logic [WDW-1:0]               wd_q;
   logic [WDW-1:0]               wd_d;
   logic                         dvalid_q;
   logic [2*WIDTH-1:0]           prod_q;
   logic                         err_q;
   logic                         fifo_push;
   logic                         fifo_pop;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [2*WIDTH-1:0]           fifo_rdata;
   logic [$clog2(DEPTH+1)-1:0]   fifo_count;

   // Both interfaces transfer on the rising edge where valid && ready are high; a valid
   // side holds its payload until that edge, and ready never depends on the partner's valid.
   assign src_ready = !rst && !fifo_full;
   assign fifo_push = src_valid && src_ready;
   assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

   mult_op_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata ({src_multiplicand, src_multiplier}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign wd_d = wd_q + WDW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         start_q  <= 1'b0;
         wd_q     <= '0;
         dvalid_q <= 1'b0;
         prod_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  {mcand_q, mplier_q} <= fifo_rdata;
                  start_q             <= 1'b1;
                  state_q             <= ISSUE;
               end
            end
            ISSUE: begin
               wd_q    <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               // A done arriving on the last watchdog cycle still counts as success.
               if (mul_done) begin
                  prod_q   <= mul_product;
                  dvalid_q <= 1'b1;
                  state_q  <= HOLD;
               end else if (wd_q == WD_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  wd_q <= wd_d;
               end
            end
            HOLD: begin
               if (dst_ready) begin
                  dvalid_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mul_start        = start_q;
   assign mul_multiplicand = mcand_q;
   assign mul_multiplier   = mplier_q;
   assign dst_valid        = dvalid_q;
   assign dst_product      = prod_q;
   assign err              = err_q;
   assign busy             = !rst && ((state_q != IDLE) || (fifo_count != '0));
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl with a behavioural sequential-multiplier model.
module tb_mult_issue_ctrl;
   import mult_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         src_valid;
   logic         src_ready;
   logic [15:0]  src_multiplicand;
   logic [15:0]  src_multiplier;
   logic         mul_start;
   logic [15:0]  mul_multiplicand;
   logic [15:0]  mul_multiplier;
   logic         mul_done;
   logic [31:0]  mul_product;
   logic         dst_valid;
   logic         dst_ready;
   logic [31:0]  dst_product;
   logic         busy;
   logic         err;
   issue_state_t dbg_state;

   int           n_vec = 0;
   int           n_fail = 0;
   logic [31:0]  exp_q[$];
   int           cyc = 0;
   int           n_starts = 0;
   int           last_start_cyc = 0;
   int           prev_start_cyc = 0;
   int           mdl_lat = 17;
   bit           mdl_never = 1'b0;
   bit           stray_req = 1'b0;
   bit           mdl_busy;
   int           mdl_cnt;
   logic [31:0]  mdl_prod;

   mult_issue_ctrl #(.WIDTH(16), .DEPTH(2), .TIMEOUT(40)) dut (
      .clk              (clk),
      .rst              (rst),
      .src_valid        (src_valid),
      .src_ready        (src_ready),
      .src_multiplicand (src_multiplicand),
      .src_multiplier   (src_multiplier),
      .mul_start        (mul_start),
      .mul_multiplicand (mul_multiplicand),
      .mul_multiplier   (mul_multiplier),
      .mul_done         (mul_done),
      .mul_product      (mul_product),
      .dst_valid        (dst_valid),
      .dst_ready        (dst_ready),
      .dst_product      (dst_product),
      .busy             (busy),
      .err              (err),
      .dbg_state        (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout bench did not finish");
      $fatal(1, "bench timed out");
   end

   function automatic logic [31:0] prod32(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return sa * sb;
   endfunction

   // Multiplier model: done pulse mdl_lat cycles after the start cycle.
   initial begin
      mul_done    = 1'b0;
      mul_product = '0;
      mdl_busy    = 1'b0;
      mdl_cnt     = 0;
      mdl_prod    = '0;
      forever begin
         @(posedge clk);
         #2;
         mul_done = 1'b0;
         if (rst) begin
            mdl_busy = 1'b0;
         end else begin
            if (mdl_busy) begin
               mdl_cnt--;
               if (mdl_cnt == 0) begin
                  mul_done    = 1'b1;
                  mul_product = mdl_prod;
                  mdl_busy    = 1'b0;
               end
            end
            if (stray_req) begin
               mul_done    = 1'b1;
               mul_product = 32'hDEADBEEF;
            end
            if (mul_start === 1'b1 && !mdl_never) begin
               mdl_busy = 1'b1;
               mdl_cnt  = mdl_lat;
               mdl_prod = prod32(mul_multiplicand, mul_multiplier);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Samples the cycle (start bookkeeping, scoreboard) at negedge, then steps past the edge.
   task automatic tick();
      logic [31:0] exp;
      @(negedge clk);
      if (mul_start === 1'b1) begin
         n_starts++;
         prev_start_cyc = last_start_cyc;
         last_start_cyc = cyc;
      end
      if (!rst && dst_valid === 1'b1 && dst_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected got=%h exp=<none>", dst_product);
         end else begin
            exp = exp_q.pop_front();
            if (dst_product !== exp) begin
               n_fail++;
               $display("FAIL sb_product got=%h exp=%h", dst_product, exp);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(input logic [15:0] m, input logic [15:0] q, input bit expect_res);
      int n = 0;
      src_valid        = 1'b1;
      src_multiplicand = m;
      src_multiplier   = q;
      while (src_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (expect_res) exp_q.push_back(prod32(m, q));
      tick();
      src_valid = 1'b0;
   endtask

   task automatic wait_dv(input int max_cyc, output bit ok);
      int n = 0;
      while (dst_valid !== 1'b1 && n < max_cyc) begin
         tick();
         n++;
      end
      ok = (dst_valid === 1'b1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; src_valid = 1'b0; src_multiplicand = '0; src_multiplier = '0; dst_ready = 1'b0;
      repeat (3) tick();
      n_vec++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL rst_src_ready got=%b exp=0", src_ready); end
      n_vec++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL rst_mul_start got=%b exp=0", mul_start); end
      n_vec++; if ({mul_multiplicand, mul_multiplier} !== 32'h0) begin n_fail++; $display("FAIL rst_operands got=%h exp=0", {mul_multiplicand, mul_multiplier}); end
      n_vec++; if (dst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dst_valid got=%b exp=0", dst_valid); end
      n_vec++; if (dst_product !== 32'h0) begin n_fail++; $display("FAIL rst_dst_product got=%h exp=0", dst_product); end
      n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
      n_vec++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
      rst = 1'b0;
      tick();
      n_vec++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", src_ready); end
   endtask

   task automatic test_single();
      bit ok;
      int s0;
      mdl_lat = 17; dst_ready = 1'b1; s0 = n_starts;
      push_op(16'd3, 16'd5, 1'b1);
      n_vec++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got=%b exp=0", mul_start); end
      tick();
      n_vec++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL single_start got=%b exp=1", mul_start); end
      n_vec++; if ({mul_multiplicand, mul_multiplier} !== {16'd3, 16'd5}) begin n_fail++; $display("FAIL single_operands got=%h exp=%h", {mul_multiplicand, mul_multiplier}, {16'd3, 16'd5}); end
      n_vec++; if (dbg_state !== ISSUE) begin n_fail++; $display("FAIL single_issue_state got=%0d exp=%0d", dbg_state, ISSUE); end
      tick();
      n_vec++; if (mul_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse got=%b exp=0", mul_start); end
      n_vec++; if (dbg_state !== WAIT) begin n_fail++; $display("FAIL single_wait_state got=%0d exp=%0d", dbg_state, WAIT); end
      wait_dv(60, ok);
      n_vec++; if (!ok) begin n_fail++; $display("FAIL single_dv_timeout got=0 exp=1"); end
      n_vec++; if (cyc - last_start_cyc != 18) begin n_fail++; $display("FAIL single_latency got=%0d exp=18", cyc - last_start_cyc); end
      n_vec++; if (dst_product !== 32'h0000000F) begin n_fail++; $display("FAIL single_product got=%h exp=0000000f", dst_product); end
      tick();
      n_vec++; if (busy !== 1'b0 || dst_valid !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall got=%b%b exp=00", busy, dst_valid); end
      n_vec++; if (n_starts - s0 != 1) begin n_fail++; $display("FAIL single_start_count got=%0d exp=1", n_starts - s0); end
   endtask

   task automatic test_hold();
      bit ok;
      int s0;
      mdl_lat = 9; dst_ready = 1'b0;
      push_op(16'hFFF9, 16'd6, 1'b1);
      wait_dv(40, ok);
      n_vec++; if (!ok) begin n_fail++; $display("FAIL hold_dv_timeout got=0 exp=1"); end
      s0 = n_starts;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_vec++;
         if (dst_valid !== 1'b1 || dst_product !== 32'hFFFFFFD6) begin
            n_fail++;
            $display("FAIL hold_stable cyc%0d got=%b/%h exp=1/ffffffd6", i, dst_valid, dst_product);
         end
      end
      n_vec++; if (n_starts != s0) begin n_fail++; $display("FAIL hold_no_restart got=%0d exp=%0d", n_starts, s0); end
      n_vec++; if (dbg_state !== HOLD) begin n_fail++; $display("FAIL hold_state got=%0d exp=%0d", dbg_state, HOLD); end
      dst_ready = 1'b1;
      tick();
      n_vec++; if (dst_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got=%b exp=0", dst_valid); end
   endtask

   task automatic test_back_to_back();
      op_pair_t ops [3];
      int n = 0;
      ops[0] = '{m: 16'd10, q: 16'd10};
      ops[1] = '{m: 16'd2, q: 16'hFFFF};
      ops[2] = '{m: 16'h8000, q: 16'h8000};
      mdl_lat = 17; dst_ready = 1'b1;
      for (int i = 0; i < 3; i++) push_op(ops[i].m, ops[i].q, 1'b1);
      n_vec++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got=%b exp=0", src_ready); end
      n_vec++; if (dbg_state !== WAIT) begin n_fail++; $display("FAIL b2b_inflight_state got=%0d exp=%0d", dbg_state, WAIT); end
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain got=%0d exp=0", exp_q.size()); end
      n_vec++; if (last_start_cyc - prev_start_cyc != 20) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=20", last_start_cyc - prev_start_cyc); end
      n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", busy); end
   endtask

   task automatic test_stray_done();
      bit ok;
      dst_ready = 1'b1;
      stray_req = 1'b1; tick(); stray_req = 1'b0; tick();
      n_vec++; if (dbg_state !== IDLE || dst_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stray_idle got=%0d/%b/%b exp=0/0/0", dbg_state, dst_valid, busy); end
      n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL stray_idle_err got=%b exp=0", err); end
      mdl_lat = 5; dst_ready = 1'b0;
      push_op(16'd100, 16'hFFFD, 1'b1);
      wait_dv(30, ok);
      n_vec++; if (!ok) begin n_fail++; $display("FAIL stray_hold_dv got=0 exp=1"); end
      stray_req = 1'b1; tick(); stray_req = 1'b0; tick();
      n_vec++; if (dbg_state !== HOLD || dst_product !== 32'hFFFFFED4) begin n_fail++; $display("FAIL stray_hold got=%0d/%h exp=%0d/fffffed4", dbg_state, dst_product, HOLD); end
      dst_ready = 1'b1;
      tick();
      mdl_lat = 40;
      push_op(16'hFB2E, 16'h0237, 1'b1);
      wait_dv(80, ok);
      n_vec++; if (!ok) begin n_fail++; $display("FAIL last_cycle_done_dv got=0 exp=1"); end
      n_vec++; if (cyc - last_start_cyc != 41) begin n_fail++; $display("FAIL last_cycle_latency got=%0d exp=41", cyc - last_start_cyc); end
      n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL last_cycle_err got=%b exp=0", err); end
      tick();
   endtask

   task automatic test_timeout();
      bit ok;
      int n = 0;
      mdl_lat = 17; mdl_never = 1'b1; dst_ready = 1'b1;
      push_op(16'd11, 16'd13, 1'b0);
      push_op(16'hFFFB, 16'hFFF7, 1'b1);
      while (err !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      mdl_never = 1'b0;
      n_vec++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got=%b exp=1", err); end
      n_vec++; if (cyc - (last_start_cyc + 1) != 40) begin n_fail++; $display("FAIL timeout_cycles got=%0d exp=40", cyc - (last_start_cyc + 1)); end
      n_vec++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL timeout_state got=%0d exp=%0d", dbg_state, IDLE); end
      tick();
      n_vec++; if (mul_start !== 1'b1 || mul_multiplicand !== 16'hFFFB) begin n_fail++; $display("FAIL timeout_next_issue got=%b/%h exp=1/fffb", mul_start, mul_multiplicand); end
      wait_dv(40, ok);
      n_vec++; if (!ok) begin n_fail++; $display("FAIL timeout_next_dv got=0 exp=1"); end
      tick();
      n_vec++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got=%b exp=1", err); end
   endtask

   task automatic test_reset_mid();
      int s0;
      mdl_lat = 17; dst_ready = 1'b1;
      push_op(16'd21, 16'd22, 1'b0);
      push_op(16'd23, 16'd24, 1'b0);
      tick(); tick();
      n_vec++; if (dbg_state !== WAIT || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got=%0d/%b exp=%0d/1", dbg_state, busy, WAIT); end
      s0 = n_starts;
      rst = 1'b1;
      tick();
      n_vec++; if (src_ready !== 1'b0 || mul_start !== 1'b0 || dst_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl got=%b%b%b exp=000", src_ready, mul_start, dst_valid); end
      n_vec++; if ({mul_multiplicand, mul_multiplier} !== 32'h0 || dst_product !== 32'h0) begin n_fail++; $display("FAIL rmid_data got=%h/%h exp=0/0", {mul_multiplicand, mul_multiplier}, dst_product); end
      n_vec++; if (busy !== 1'b0 || err !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL rmid_status got=%b/%b/%0d exp=0/0/0", busy, err, dbg_state); end
      rst = 1'b0;
      tick();
      n_vec++; if (src_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_fifo_empty got=%b/%b exp=1/0", src_ready, busy); end
      stray_req = 1'b1; tick(); stray_req = 1'b0;
      repeat (3) tick();
      n_vec++; if (dbg_state !== IDLE || dst_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_late_done got=%0d/%b/%b exp=0/0/0", dbg_state, dst_valid, busy); end
      n_vec++; if (n_starts != s0) begin n_fail++; $display("FAIL rmid_no_issue got=%0d exp=%0d", n_starts, s0); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_hold();
      test_back_to_back();
      test_stray_done();
      test_timeout();
      test_reset_mid();
      n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
